// File: rtl/acoustic_capture_buffer.sv
// Acoustic capture buffer: keeps a circular pre-trigger history of ADC words,
// fires when a sample's distance from midscale exceeds a threshold, freezes a
// DEPTH-sample window around the trigger and streams it out oldest-first.
module acoustic_capture_buffer #(
    parameter int DATA_W   = 10,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int PRE      = 16,
    parameter int MIDSCALE = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] threshold,
    input  logic              arm,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic              triggered,
    output logic [7:0]        dropped
);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READOUT} state_t;

    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(DEPTH - PRE - 1);
    localparam logic [ADDR_W:0]   WORDS     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q, fill_cnt_q, post_cnt_q;
    logic [ADDR_W:0]     ld_cnt_q;      // words moved into the output register
    logic                ram_vld_q;     // ram_q holds a real window word
    logic [DATA_W-1:0]   ram_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q, rd_last_q, triggered_q;
    logic [7:0]          dropped_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic signed [DATA_W:0] diff;
    logic [DATA_W:0]        mag;
    logic                   over_thr, we, fire, load, drop_inc;
    logic [ADDR_W-1:0]      raddr;

    // Magnitude of the sample around midscale and the per-cycle control strobes
    always_comb begin
        diff     = $signed({1'b0, sample_in}) - $signed((DATA_W+1)'(MIDSCALE));
        mag      = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
        over_thr = mag > {1'b0, threshold};
        we       = sample_valid && (state_q == FILL || state_q == ARMED || state_q == POST);
        fire     = rd_valid_q && rd_ready;
        // Refill the output register when it is empty or being consumed; the
        // RAM pre-reads the following address in the same cycle so accepts
        // can run back to back.
        load     = (state_q == READOUT) && ram_vld_q && (ld_cnt_q != WORDS)
                   && (!rd_valid_q || fire);
        raddr    = load ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        drop_inc = sample_valid && ((state_q == IDLE && !arm) || state_q == READOUT);
    end

    // Sample RAM: synchronous write, synchronous read
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= sample_in;
        ram_q <= mem[raddr];
    end

    // Capture/readout state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            ld_cnt_q    <= '0;
            ram_vld_q   <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            triggered_q <= 1'b0;
            dropped_q   <= '0;
        end else begin
            if (we) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);

            case (state_q)
                IDLE: if (arm) begin
                    state_q    <= FILL;
                    fill_cnt_q <= '0;
                end
                FILL: if (sample_valid) begin
                    fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
                    if (fill_cnt_q == FILL_LAST) state_q <= ARMED;
                end
                ARMED: if (sample_valid && over_thr) begin
                    triggered_q <= 1'b1;
                    post_cnt_q  <= POST_LOAD;
                    state_q     <= POST;
                end
                POST: if (sample_valid) begin
                    post_cnt_q <= post_cnt_q - ADDR_W'(1);
                    if (post_cnt_q == ADDR_W'(1)) begin
                        // wr_ptr after this write lands on the window start
                        state_q   <= READOUT;
                        rd_ptr_q  <= wr_ptr_q + ADDR_W'(1);
                        ld_cnt_q  <= '0;
                        ram_vld_q <= 1'b0;
                    end
                end
                READOUT: begin
                    ram_vld_q <= 1'b1;
                    if (fire && rd_last_q) begin
                        state_q     <= IDLE;
                        rd_valid_q  <= 1'b0;
                        rd_last_q   <= 1'b0;
                        triggered_q <= 1'b0;
                    end else if (load) begin
                        rd_data_q  <= ram_q;
                        rd_valid_q <= 1'b1;
                        rd_last_q  <= (ld_cnt_q == LAST_IDX);
                        ld_cnt_q   <= ld_cnt_q + (ADDR_W+1)'(1);
                        rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (state_q == IDLE && arm) dropped_q <= '0;
            else if (drop_inc && dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = (state_q != IDLE);
    assign triggered = triggered_q;
    assign dropped   = dropped_q;

endmodule
